fm_readout_sched: RTL and testbench

//  Sequences readout of the per-kernel feature-map RAM buffers into the np_matrix_mult

---
 rtl/fm_readout_sched_pkg.sv | 20 ++
 rtl/fm_valid_delay.sv | 52 +++++
 rtl/fm_readout_sched.sv | 122 ++++++++++++
 tb/tb_fm_readout_sched.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fm_readout_sched_pkg.sv
// Shared constants for the feature-map readout scheduler: default geometry and FSM encodings.
// Also holds a small helper that decides how weight indices are formed.
package fm_readout_sched_pkg;

    localparam int NUM_KERNELS      = 4;
    localparam int FM_ADDR_BITWIDTH = 6;
    localparam int FM_DEPTH_DEF     = 64;

    typedef logic [1:0] fsm_state_t;

    localparam fsm_state_t ST_IDLE  = 2'd0;
    localparam fsm_state_t ST_READ  = 2'd1;
    localparam fsm_state_t ST_DRAIN = 2'd2;
    localparam fsm_state_t ST_DONE  = 2'd3;

    function automatic bit is_pow2(input int n);
        return (n > 0) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/fm_valid_delay.sv
// Aligns issue-side tags {valid, last, weight index} with RAM read data.
// Latency: DEPTH cycles, fixed.
// Backpressure: none; shifts every cycle, synchronous active-low clear empties it.
module fm_valid_delay #(
    parameter int DEPTH   = 2,
    parameter int WADDR_W = 8
) (
    input  logic               clock,
    input  logic               clr_n,
    input  logic               in_vld,
    input  logic               in_last,
    input  logic [WADDR_W-1:0] in_waddr,
    output logic               out_vld,
    output logic               out_last,
    output logic [WADDR_W-1:0] out_waddr,
    output logic               pending
);

    typedef struct packed {
        logic               vld;
        logic               last;
        logic [WADDR_W-1:0] waddr;
    } tag_t;

    tag_t stage [DEPTH];

    always_ff @(posedge clock) begin
        if (!clr_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= '{vld: in_vld, last: in_last, waddr: in_waddr};
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign out_vld   = stage[DEPTH-1].vld;
    assign out_last  = stage[DEPTH-1].last;
    assign out_waddr = stage[DEPTH-1].waddr;

    // Entries still behind the output stage; the line is empty after the next edge when clear.
    always_comb begin
        pending = 1'b0;
        for (int i = 0; i < DEPTH - 1; i++) begin
            pending = pending | stage[i].vld;
        end
    end

endmodule

// File: rtl/fm_readout_sched.sv
// Sweeps every feature-map buffer through the read mux into the matrix-multiply array.
// Latency: pixel_valid follows each issued read by RAM_LATENCY cycles; done one cycle after last pixel.
// Backpressure: mm_ready low stalls issue (address holds); reads already in flight still emerge.
module fm_readout_sched
    import fm_readout_sched_pkg::*;
#(
    parameter int NUM_KERNELS = fm_readout_sched_pkg::NUM_KERNELS,
    parameter int FM_DEPTH    = FM_DEPTH_DEF,
    parameter int ADDR_W      = FM_ADDR_BITWIDTH,
    parameter int SEL_W       = 2,
    parameter int WADDR_W     = 8,
    parameter int RAM_LATENCY = 2
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               buffer_full,
    input  logic               mm_ready,
    output logic [SEL_W-1:0]   ram_select,
    output logic [ADDR_W-1:0]  rd_addr,
    output logic               pixel_valid,
    output logic [WADDR_W-1:0] weight_addr,
    output logic               last_pixel,
    output logic               busy,
    output logic               done,
    output logic               buffer_release
);

    localparam logic [ADDR_W-1:0] ADDR_MAX = ADDR_W'(FM_DEPTH - 1);
    localparam logic [SEL_W-1:0]  SEL_MAX  = SEL_W'(NUM_KERNELS - 1);

    fsm_state_t         state;
    logic               issue;
    logic               issue_last;
    logic [WADDR_W-1:0] issue_waddr;
    logic [WADDR_W-1:0] tag_waddr;
    logic               tail_pending;

    assign issue      = (state == ST_READ) && mm_ready;
    assign issue_last = issue && (ram_select == SEL_MAX) && (rd_addr == ADDR_MAX);

    always_ff @(posedge clock) begin
        if (!reset) begin
            state      <= ST_IDLE;
            ram_select <= '0;
            rd_addr    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (buffer_full) begin
                        state      <= ST_READ;
                        ram_select <= '0;
                        rd_addr    <= '0;
                    end
                end
                ST_READ: begin
                    // The final issue leaves sel/addr at their last values for DRAIN and DONE.
                    if (issue_last) begin
                        state <= ST_DRAIN;
                    end else if (issue) begin
                        if (rd_addr == ADDR_MAX) begin
                            rd_addr    <= '0;
                            ram_select <= ram_select + SEL_W'(1);
                        end else begin
                            rd_addr <= rd_addr + ADDR_W'(1);
                        end
                    end
                end
                ST_DRAIN: begin
                    if (!tail_pending) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    generate
        if (is_pow2(FM_DEPTH)) begin : g_concat
            localparam int LOG2_D = $clog2(FM_DEPTH);
            assign issue_waddr = (WADDR_W'(ram_select) << LOG2_D) | WADDR_W'(rd_addr);
        end else begin : g_count
            // Non power-of-two depth: sel*FM_DEPTH+addr is just the running issue count.
            logic [WADDR_W-1:0] waddr_cnt;
            always_ff @(posedge clock) begin
                if (!reset || (state == ST_IDLE)) begin
                    waddr_cnt <= '0;
                end else if (issue) begin
                    waddr_cnt <= waddr_cnt + WADDR_W'(1);
                end
            end
            assign issue_waddr = waddr_cnt;
        end
    endgenerate

    assign tag_waddr = issue ? issue_waddr : '0;

    fm_valid_delay #(
        .DEPTH   (RAM_LATENCY),
        .WADDR_W (WADDR_W)
    ) u_valid_delay (
        .clock     (clock),
        .clr_n     (reset),
        .in_vld    (issue),
        .in_last   (issue_last),
        .in_waddr  (tag_waddr),
        .out_vld   (pixel_valid),
        .out_last  (last_pixel),
        .out_waddr (weight_addr),
        .pending   (tail_pending)
    );

    assign busy           = (state == ST_READ) || (state == ST_DRAIN);
    assign done           = (state == ST_DONE);
    assign buffer_release = (state == ST_DONE);

endmodule

// File: tb/tb_fm_readout_sched.sv
// Scoreboard bench: stimulus pushes expected pixels/done cycles, a negedge monitor pops and compares.
module tb_fm_readout_sched;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_pass = 0;

    // Main instance: 2 kernels x 4 pixels
    logic       reset, buffer_full, mm_ready;
    logic [0:0] ram_select;
    logic [1:0] rd_addr;
    logic       pixel_valid, last_pixel, busy, done, buffer_release;
    logic [2:0] weight_addr;

    fm_readout_sched #(.NUM_KERNELS(2), .FM_DEPTH(4), .ADDR_W(2), .SEL_W(1), .WADDR_W(3), .RAM_LATENCY(2)) u_dut (
        .clock(clock), .reset(reset), .buffer_full(buffer_full), .mm_ready(mm_ready),
        .ram_select(ram_select), .rd_addr(rd_addr), .pixel_valid(pixel_valid), .weight_addr(weight_addr),
        .last_pixel(last_pixel), .busy(busy), .done(done), .buffer_release(buffer_release));

    // Side instances: non power-of-two depth (2x3) and degenerate 1x1
    logic       rst_x, bf3, bf6, mm_x;
    logic [0:0] s3_sel, s6_sel, s6_addr, s6_waddr;
    logic [1:0] s3_addr;
    logic [2:0] s3_waddr;
    logic       s3_vld, s3_last, s3_busy, s3_done, s3_rel;
    logic       s6_vld, s6_last, s6_busy, s6_done, s6_rel;

    fm_readout_sched #(.NUM_KERNELS(2), .FM_DEPTH(3), .ADDR_W(2), .SEL_W(1), .WADDR_W(3), .RAM_LATENCY(2)) u_np2 (
        .clock(clock), .reset(rst_x), .buffer_full(bf3), .mm_ready(mm_x),
        .ram_select(s3_sel), .rd_addr(s3_addr), .pixel_valid(s3_vld), .weight_addr(s3_waddr),
        .last_pixel(s3_last), .busy(s3_busy), .done(s3_done), .buffer_release(s3_rel));

    fm_readout_sched #(.NUM_KERNELS(1), .FM_DEPTH(1), .ADDR_W(1), .SEL_W(1), .WADDR_W(1), .RAM_LATENCY(2)) u_one (
        .clock(clock), .reset(rst_x), .buffer_full(bf6), .mm_ready(mm_x),
        .ram_select(s6_sel), .rd_addr(s6_addr), .pixel_valid(s6_vld), .weight_addr(s6_waddr),
        .last_pixel(s6_last), .busy(s6_busy), .done(s6_done), .buffer_release(s6_rel));

    typedef struct {
        int cyc;
        int waddr;
        bit last;
    } px_t;

    px_t px_q[$];
    int  done_q[$];

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // Move to just after the rising edge that starts cycle k (inputs driven here).
    task automatic go_cyc(input int k);
        do begin
            @(posedge clock);
            #1;
        end while (cyc < k);
    endtask

    // Move to the falling edge inside cycle k (outputs sampled here).
    task automatic wait_neg(input int k);
        do @(negedge clock); while (cyc < k);
    endtask

    // Expected response of a sweep whose buffer_full is sampled in cycle c0,
    // with mm_ready low in cycles [st_s, st_s+st_n).
    task automatic push_sweep(input int c0, input int total, input int st_s, input int st_n);
        int t = c0 + 1;
        int k = 0;
        px_t e;
        while (k < total) begin
            if (!(t >= st_s && t < st_s + st_n)) begin
                e.cyc   = t + 2;
                e.waddr = k;
                e.last  = (k == total - 1);
                px_q.push_back(e);
                k++;
            end
            t++;
        end
        done_q.push_back(t + 2);
    endtask

    always @(negedge clock) begin : monitor
        px_t e;
        int  d;
        if (pixel_valid === 1'b1) begin
            if (px_q.size() == 0) begin
                chk("unexpected_pixel_valid", pixel_valid, 0);
            end else begin
                e = px_q.pop_front();
                chk("pixel_cycle", cyc, e.cyc);
                chk("weight_addr", weight_addr, e.waddr);
                chk("last_pixel", last_pixel, e.last);
            end
        end else if (last_pixel === 1'b1) begin
            chk("last_without_valid", last_pixel, 0);
        end
        if (done === 1'b1) begin
            if (done_q.size() == 0) begin
                chk("unexpected_done", done, 0);
            end else begin
                d = done_q.pop_front();
                chk("done_cycle", cyc, d);
                chk("buffer_release_with_done", buffer_release, 1);
            end
        end else if (buffer_release === 1'b1) begin
            chk("release_without_done", buffer_release, 0);
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin : stim
        int c0, c1, c2, c3, c4, c5, c6;
        reset = 1'b0; buffer_full = 1'b1; mm_ready = 1'b1;
        rst_x = 1'b0; bf3 = 1'b0; bf6 = 1'b0; mm_x = 1'b1;

        // Reset held with buffer_full high: everything stays quiet
        for (int i = 1; i <= 3; i++) begin
            wait_neg(i);
            chk("reset_outputs",
                {ram_select, rd_addr, pixel_valid, weight_addr, last_pixel, busy, done, buffer_release}, 0);
        end

        // Plain sweep
        go_cyc(4);
        reset = 1'b1;
        c0 = cyc;
        push_sweep(c0, 8, 0, 0);
        go_cyc(c0 + 1);
        buffer_full = 1'b0;
        wait_neg(c0 + 1);
        chk("first_issue_busy", busy, 1);
        chk("first_issue_addr", {ram_select, rd_addr}, 0);
        wait_neg(c0 + 5);
        chk("kernel_wrap_sel", ram_select, 1);
        chk("kernel_wrap_addr", rd_addr, 0);
        wait_neg(c0 + 10);
        chk("busy_at_last_pixel", busy, 1);
        wait_neg(c0 + 11);
        chk("busy_in_done", busy, 0);
        chk("hold_sel_in_done", ram_select, 1);
        chk("hold_addr_in_done", rd_addr, 3);

        // Sweep with mm_ready low in cycles 3..5
        go_cyc(c0 + 13);
        buffer_full = 1'b1;
        c1 = cyc;
        push_sweep(c1, 8, c1 + 3, 3);
        go_cyc(c1 + 1);
        buffer_full = 1'b0;
        go_cyc(c1 + 3);
        mm_ready = 1'b0;
        wait_neg(c1 + 3);
        chk("stall_addr_c3", rd_addr, 2);
        wait_neg(c1 + 5);
        chk("stall_addr_c5", rd_addr, 2);
        chk("stall_sel_c5", ram_select, 0);
        go_cyc(c1 + 6);
        mm_ready = 1'b1;

        // buffer_full held across done: back-to-back sweeps
        go_cyc(c1 + 15);
        buffer_full = 1'b1;
        c2 = cyc;
        c3 = c2 + 12;
        push_sweep(c2, 8, 0, 0);
        push_sweep(c3, 8, 0, 0);
        go_cyc(c3 + 1);
        buffer_full = 1'b0;
        wait_neg(c3 + 1);
        chk("restart_busy", busy, 1);
        chk("restart_addr", {ram_select, rd_addr}, 0);

        // Reset in cycle 5 of a sweep: three pixels emerge, then silence
        go_cyc(c3 + 13);
        buffer_full = 1'b1;
        c4 = cyc;
        for (int k = 0; k < 3; k++) begin
            px_q.push_back('{c4 + 3 + k, k, 1'b0});
        end
        go_cyc(c4 + 1);
        buffer_full = 1'b0;
        go_cyc(c4 + 5);
        reset = 1'b0;
        wait_neg(c4 + 6);
        chk("midsweep_reset_outputs",
            {ram_select, rd_addr, pixel_valid, weight_addr, last_pixel, busy, done, buffer_release}, 0);
        go_cyc(c4 + 8);
        reset = 1'b1;
        buffer_full = 1'b1;
        c5 = cyc;
        push_sweep(c5, 8, 0, 0);
        go_cyc(c5 + 1);
        buffer_full = 1'b0;
        wait_neg(c5 + 1);
        chk("post_reset_addr", {ram_select, rd_addr}, 0);
        wait_neg(c5 + 14);
        chk("pixels_outstanding", px_q.size(), 0);
        chk("done_outstanding", done_q.size(), 0);

        // Non power-of-two depth and 1x1 geometry, started together
        go_cyc(c5 + 15);
        rst_x = 1'b1;
        bf3 = 1'b1;
        bf6 = 1'b1;
        c6 = cyc;
        go_cyc(c6 + 1);
        bf3 = 1'b0;
        bf6 = 1'b0;
        for (int n = 1; n <= 10; n++) begin
            wait_neg(c6 + n);
            if (n == 1) chk("one_busy", s6_busy, 1);
            if (n == 2) chk("one_no_early_pixel", s6_vld, 0);
            if (n == 3) chk("one_pixel_last", {s6_vld, s6_last, s6_waddr}, 3'b110);
            if (n == 4) chk("one_done_release", {s6_done, s6_rel, s6_vld}, 3'b110);
            if (n == 5) chk("one_idle", {s6_done, s6_busy}, 0);
            if (n == 4) chk("np2_wrap", {s3_sel, s3_addr}, 3'b100);
            if (n >= 3 && n <= 8) begin
                chk("np2_valid", s3_vld, 1);
                chk("np2_weight_addr", s3_waddr, n - 3);
                chk("np2_last", s3_last, (n == 8) ? 1 : 0);
            end
            if (n == 9) chk("np2_done", {s3_done, s3_rel, s3_vld}, 3'b110);
            if (n == 10) chk("np2_idle", {s3_done, s3_busy, s3_vld}, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
